// File: rtl/bus_gate_mux_pkg.sv
// Shared constants for the gated datapath bus resolver.
package bus_mux_pkg;

  localparam int BUS_WIDTH_DEFAULT = 16;
  localparam int CNT_W_DEFAULT     = 8;

  // LC-3 source slots on the shared datapath bus
  localparam int SRC_PC     = 0;
  localparam int SRC_MDR    = 1;
  localparam int SRC_ALU    = 2;
  localparam int SRC_MARMUX = 3;

  // Per-cycle resolution flags for the bus value
  typedef struct packed {
    logic valid;
    logic conflict;
  } bus_flags_t;

endpackage

// File: rtl/bus_gate_mux_if.sv
// Gated-source bus bundle: sources and gates in, resolved bus and conflict status out.
interface bus_gate_mux_if
  import bus_mux_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH_DEFAULT,
  parameter int N_SRC = 4,
  parameter int CNT_W = CNT_W_DEFAULT
);
  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC*WIDTH-1:0] src_data;
  logic [N_SRC-1:0]       gate;
  logic                   clr_err;
  logic [WIDTH-1:0]       bus_out;
  logic                   bus_valid;
  logic [SRC_W-1:0]       bus_src;
  logic                   conflict;
  logic                   conflict_sticky;
  logic [CNT_W-1:0]       conflict_count;

  modport master (
    output src_data, gate, clr_err,
    input  bus_out, bus_valid, bus_src, conflict, conflict_sticky, conflict_count
  );

  modport slave (
    input  src_data, gate, clr_err,
    output bus_out, bus_valid, bus_src, conflict, conflict_sticky, conflict_count
  );

endinterface

// File: rtl/bus_gate_mux_prio_enc.sv
// Lowest-index-wins encoder for the gate vector, with any/multi-hot detection.
module onehot_prio_enc #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     gate,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // Scan from the top down so the lowest set bit is the last to be written
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (gate[i]) idx = IDX_W'(i);
    end
  end

  assign any   = |gate;
  // Clearing the lowest set bit leaves something only when two or more were set
  assign multi = (gate & (gate - N'(1))) != '0;

endmodule

// File: rtl/bus_gate_mux.sv
// Shared datapath bus: resolves gated sources, keeps the last value when idle,
// and tracks gate conflicts with a sticky flag and a saturating counter.
module bus_gate_mux
  import bus_mux_pkg::*;
#(
  parameter int WIDTH      = BUS_WIDTH_DEFAULT,
  parameter int N_SRC      = 4,
  parameter int REGISTERED = 0,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input logic          Clk,
  input logic          Reset,
  bus_gate_mux_if.slave bus
);

  localparam int SRC_W = $clog2(N_SRC);

  logic [SRC_W-1:0] win_idx;
  logic             any_gate;
  logic             multi_gate;

  logic [WIDTH-1:0] keeper;
  logic [SRC_W-1:0] keeper_src;

  logic [WIDTH-1:0] comb_out;
  logic [SRC_W-1:0] comb_src;
  bus_flags_t       comb_flags;

  logic             sticky;
  logic [CNT_W-1:0] count;

  onehot_prio_enc #(.N(N_SRC)) u_enc (
    .gate  (bus.gate),
    .idx   (win_idx),
    .any   (any_gate),
    .multi (multi_gate)
  );

  // Resolve this cycle's bus value: winner when gated, keeper when idle, zero in reset
  always_comb begin
    comb_out            = keeper;
    comb_src            = keeper_src;
    comb_flags.valid    = 1'b0;
    comb_flags.conflict = 1'b0;
    if (Reset) begin
      comb_out = '0;
      comb_src = '0;
    end else if (any_gate) begin
      comb_out            = bus.src_data[win_idx*WIDTH +: WIDTH];
      comb_src            = win_idx;
      comb_flags.valid    = 1'b1;
      comb_flags.conflict = multi_gate;
    end
  end

  // Bus keeper follows whichever source won the bus
  always_ff @(posedge Clk) begin
    if (Reset) begin
      keeper     <= '0;
      keeper_src <= '0;
    end else if (any_gate) begin
      keeper     <= comb_out;
      keeper_src <= win_idx;
    end
  end

  // Conflict tracking; a clear coinciding with a conflict restarts the count at one
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sticky <= 1'b0;
      count  <= '0;
    end else if (multi_gate) begin
      sticky <= 1'b1;
      if (bus.clr_err)  count <= CNT_W'(1);
      else if (!(&count)) count <= count + CNT_W'(1);
    end else if (bus.clr_err) begin
      sticky <= 1'b0;
      count  <= '0;
    end
  end

  assign bus.conflict_sticky = sticky;
  assign bus.conflict_count  = count;

  generate
    if (REGISTERED != 0) begin : g_reg
      // Optional timing stage: capture the resolved bus one cycle later
      always_ff @(posedge Clk) begin
        if (Reset) begin
          bus.bus_out   <= '0;
          bus.bus_valid <= 1'b0;
          bus.bus_src   <= '0;
          bus.conflict  <= 1'b0;
        end else begin
          bus.bus_out   <= comb_out;
          bus.bus_valid <= comb_flags.valid;
          bus.bus_src   <= comb_src;
          bus.conflict  <= comb_flags.conflict;
        end
      end
    end else begin : g_comb
      assign bus.bus_out   = comb_out;
      assign bus.bus_valid = comb_flags.valid;
      assign bus.bus_src   = comb_src;
      assign bus.conflict  = comb_flags.conflict;
    end
  endgenerate

endmodule

// File: tb/tb_bus_gate_mux.sv
// Bench for bus_gate_mux: combinational (8- and 4-bit counter) and registered
// instances share one stimulus stream; registered results go through a queue.
module tb_bus_gate_mux;
  import bus_mux_pkg::*;

  typedef struct {
    logic        rst;
    logic [3:0]  gate;
    logic        clr;
    logic [15:0] out;
    logic        valid;
    logic [1:0]  src;
    logic        conf;
    logic        sticky;
    logic [7:0]  count;
  } vec_t;

  typedef struct {
    logic [15:0] out;
    logic        valid;
    logic [1:0]  src;
    logic        conf;
  } bus_exp_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  bus_gate_mux_if #(.WIDTH(16), .N_SRC(4), .CNT_W(8)) if_c ();
  bus_gate_mux_if #(.WIDTH(16), .N_SRC(4), .CNT_W(4)) if_s ();
  bus_gate_mux_if #(.WIDTH(16), .N_SRC(4), .CNT_W(8)) if_r ();

  bus_gate_mux #(.WIDTH(16), .N_SRC(4), .REGISTERED(0), .CNT_W(8)) dut_c (
    .Clk(Clk), .Reset(Reset), .bus(if_c));
  bus_gate_mux #(.WIDTH(16), .N_SRC(4), .REGISTERED(0), .CNT_W(4)) dut_s (
    .Clk(Clk), .Reset(Reset), .bus(if_s));
  bus_gate_mux #(.WIDTH(16), .N_SRC(4), .REGISTERED(1), .CNT_W(8)) dut_r (
    .Clk(Clk), .Reset(Reset), .bus(if_r));

  int n_vec = 0;
  int n_err = 0;
  bus_exp_t sb_q[$];
  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic r, logic [3:0] g, logic c, logic [15:0] o, logic v,
                              logic [1:0] s, logic cf, logic st, logic [7:0] n);
    vec_t x;
    x.rst = r; x.gate = g; x.clr = c; x.out = o; x.valid = v;
    x.src = s; x.conf = cf; x.sticky = st; x.count = n;
    return x;
  endfunction

  function automatic bus_exp_t be(logic [15:0] o, logic v, logic [1:0] s, logic cf);
    bus_exp_t e;
    e.out = o; e.valid = v; e.src = s; e.conf = cf;
    return e;
  endfunction

  // One clock of stimulus: comb outputs checked at negedge, state and registered path after the edge
  task automatic cycle(input string tag, input logic rst, input logic [3:0] g, input logic clr,
                       input bus_exp_t e, input logic st, input logic [7:0] cnt_c,
                       input logic [3:0] cnt_s);
    bus_exp_t q;
    Reset = rst;
    if_c.gate = g; if_s.gate = g; if_r.gate = g;
    if_c.clr_err = clr; if_s.clr_err = clr; if_r.clr_err = clr;
    sb_q.push_back(e);
    @(negedge Clk);
    chk({tag, " c.bus_out"},   32'(if_c.bus_out),   32'(e.out));
    chk({tag, " c.bus_valid"}, 32'(if_c.bus_valid), 32'(e.valid));
    chk({tag, " c.bus_src"},   32'(if_c.bus_src),   32'(e.src));
    chk({tag, " c.conflict"},  32'(if_c.conflict),  32'(e.conf));
    chk({tag, " s.bus_out"},   32'(if_s.bus_out),   32'(e.out));
    @(posedge Clk);
    #1;
    chk({tag, " c.sticky"}, 32'(if_c.conflict_sticky), 32'(st));
    chk({tag, " c.count"},  32'(if_c.conflict_count),  32'(cnt_c));
    chk({tag, " s.sticky"}, 32'(if_s.conflict_sticky), 32'(st));
    chk({tag, " s.count"},  32'(if_s.conflict_count),  32'(cnt_s));
    chk({tag, " r.sticky"}, 32'(if_r.conflict_sticky), 32'(st));
    chk({tag, " r.count"},  32'(if_r.conflict_count),  32'(cnt_c));
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s r.queue: got empty expected entry", tag);
    end else begin
      q = sb_q.pop_front();
      chk({tag, " r.bus_out"},   32'(if_r.bus_out),   32'(q.out));
      chk({tag, " r.bus_valid"}, 32'(if_r.bus_valid), 32'(q.valid));
      chk({tag, " r.bus_src"},   32'(if_r.bus_src),   32'(q.src));
      chk({tag, " r.conflict"},  32'(if_r.conflict),  32'(q.conf));
    end
  endtask

  initial begin
    logic [63:0] srcs;
    srcs = {16'h0042, 16'hBEEF, 16'h1234, 16'h3000};
    if_c.src_data = srcs; if_s.src_data = srcs; if_r.src_data = srcs;
    Reset = 1'b1;
    if_c.gate = '1; if_s.gate = '1; if_r.gate = '1;
    if_c.clr_err = 1'b0; if_s.clr_err = 1'b0; if_r.clr_err = 1'b0;

    //            rst gate     clr out       v     src   cf    st    cnt
    tbl[0]  = mk(1, 4'b1111, 0, 16'h0000, 0, 2'd0, 0, 0, 8'd0);
    tbl[1]  = mk(1, 4'b0000, 0, 16'h0000, 0, 2'd0, 0, 0, 8'd0);
    tbl[2]  = mk(0, 4'b0000, 0, 16'h0000, 0, 2'd0, 0, 0, 8'd0);
    tbl[3]  = mk(0, 4'b0100, 0, 16'hBEEF, 1, 2'd2, 0, 0, 8'd0);
    tbl[4]  = mk(0, 4'b0010, 0, 16'h1234, 1, 2'd1, 0, 0, 8'd0);
    tbl[5]  = mk(0, 4'b0000, 0, 16'h1234, 0, 2'd1, 0, 0, 8'd0);
    tbl[6]  = mk(0, 4'b0000, 0, 16'h1234, 0, 2'd1, 0, 0, 8'd0);
    tbl[7]  = mk(0, 4'b0000, 0, 16'h1234, 0, 2'd1, 0, 0, 8'd0);
    tbl[8]  = mk(0, 4'b1010, 0, 16'h1234, 1, 2'd1, 1, 1, 8'd1);
    tbl[9]  = mk(0, 4'b0000, 0, 16'h1234, 0, 2'd1, 0, 1, 8'd1);
    tbl[10] = mk(0, 4'b1100, 0, 16'hBEEF, 1, 2'd2, 1, 1, 8'd2);
    tbl[11] = mk(0, 4'b0011, 1, 16'h3000, 1, 2'd0, 1, 1, 8'd1);
    tbl[12] = mk(0, 4'b0000, 1, 16'h3000, 0, 2'd0, 0, 0, 8'd0);
    tbl[13] = mk(0, 4'b1000, 0, 16'h0042, 1, 2'd3, 0, 0, 8'd0);
    tbl[14] = mk(0, 4'b0001, 0, 16'h3000, 1, 2'd0, 0, 0, 8'd0);
    tbl[15] = mk(0, 4'b1000, 0, 16'h0042, 1, 2'd3, 0, 0, 8'd0);
    tbl[16] = mk(0, 4'b0000, 0, 16'h0042, 0, 2'd3, 0, 0, 8'd0);
    tbl[17] = mk(0, 4'b1111, 0, 16'h3000, 1, 2'd0, 1, 1, 8'd1);
    tbl[18] = mk(1, 4'b0100, 0, 16'h0000, 0, 2'd0, 0, 0, 8'd0);
    tbl[19] = mk(0, 4'b0000, 0, 16'h0000, 0, 2'd0, 0, 0, 8'd0);

    @(posedge Clk);
    #1;

    for (int k = 0; k < 20; k++) begin
      cycle($sformatf("v%0d", k), tbl[k].rst, tbl[k].gate, tbl[k].clr,
            be(tbl[k].out, tbl[k].valid, tbl[k].src, tbl[k].conf),
            tbl[k].sticky, tbl[k].count, tbl[k].count[3:0]);
    end

    // Twenty back-to-back conflicts: 4-bit counter pins at 15, 8-bit keeps counting
    for (int k = 1; k <= 20; k++) begin
      cycle($sformatf("sat%0d", k), 1'b0, 4'b1010, 1'b0, be(16'h1234, 1'b1, 2'd1, 1'b1),
            1'b1, 8'(k), (k > 15) ? 4'd15 : 4'(k));
    end
    cycle("sat_clr", 1'b0, 4'b0000, 1'b1, be(16'h1234, 1'b0, 2'd1, 1'b0), 1'b0, 8'd0, 4'd0);

    // Registered path: one-cycle latency, then reset mid-transfer clears everything
    cycle("reg_pc",   1'b0, 4'b0001, 1'b0, be(16'h3000, 1'b1, 2'd0, 1'b0), 1'b0, 8'd0, 4'd0);
    cycle("reg_rst",  1'b1, 4'b0001, 1'b0, be(16'h0000, 1'b0, 2'd0, 1'b0), 1'b0, 8'd0, 4'd0);
    cycle("reg_idle", 1'b0, 4'b0000, 1'b0, be(16'h0000, 1'b0, 2'd0, 1'b0), 1'b0, 8'd0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
